// File: rtl/sort_pkg.sv
// Shared types for the sort sequencer: per-key payload, FSM states and drain timing.
package sort_pkg;
   localparam int INDEX_WIDTH = 16;

   typedef struct packed {
      logic [INDEX_WIDTH-1:0] frame_id;
      logic [INDEX_WIDTH-1:0] key_id;
   } id_pair_s;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DISCARD,
      S_DRAIN,
      S_READ
   } seq_state_e;

   // Cycles the sequencer waits in DRAIN before reading regardless of the sorter flag.
   function automatic int drain_timeout(input int elements);
      return elements + 3;
   endfunction
endpackage

// File: rtl/sort_sequencer_if.sv
// Upstream stream, downstream stream and sorter load/read port of the sort sequencer.
interface sort_sequencer_if
   import sort_pkg::*;
#(
   parameter int  ELEMENTS      = 64,
   parameter int  BIT_WIDTH     = 32,
   parameter type METADATA_TYPE = id_pair_s
);
   localparam int ADDR_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;

   logic                 s_valid;
   logic                 s_ready;
   logic [BIT_WIDTH-1:0] s_data;
   METADATA_TYPE         s_metadata;
   logic                 s_last;

   logic                 m_valid;
   logic                 m_ready;
   logic [BIT_WIDTH-1:0] m_data;
   METADATA_TYPE         m_metadata;
   logic                 m_last;

   logic                 srt_rst;
   logic                 srt_in_valid;
   logic [BIT_WIDTH-1:0] srt_in_data;
   METADATA_TYPE         srt_in_metadata;
   logic                 srt_in_last;
   logic [ADDR_W-1:0]    srt_out_address;
   logic                 srt_out_last;
   logic [BIT_WIDTH-1:0] srt_out_data;
   METADATA_TYPE         srt_out_metadata;

   modport master (
      input  s_valid, s_data, s_metadata, s_last, m_ready,
             srt_out_last, srt_out_data, srt_out_metadata,
      output s_ready, m_valid, m_data, m_metadata, m_last,
             srt_rst, srt_in_valid, srt_in_data, srt_in_metadata, srt_in_last,
             srt_out_address
   );

   modport slave (
      output s_valid, s_data, s_metadata, s_last, m_ready,
             srt_out_last, srt_out_data, srt_out_metadata,
      input  s_ready, m_valid, m_data, m_metadata, m_last,
             srt_rst, srt_in_valid, srt_in_data, srt_in_metadata, srt_in_last,
             srt_out_address
   );
endinterface

// File: rtl/sort_sequencer.sv
// Frames a key stream into an external sorter, waits for it to settle, then streams
// the sorted keys out in ascending address order with a registered output stage.
module sort_sequencer
   import sort_pkg::*;
#(
   parameter int  ELEMENTS      = 64,
   parameter int  BIT_WIDTH     = 32,
   parameter type METADATA_TYPE = id_pair_s,
   parameter int  CNT_W         = $clog2(ELEMENTS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   sort_sequencer_if.master bus,
   output logic             busy,
   output logic             overflow,
   output logic [CNT_W-1:0] frame_count
);
   localparam int ADDR_W = (ELEMENTS > 1) ? $clog2(ELEMENTS) : 1;
   localparam int TMR_W  = $clog2(drain_timeout(ELEMENTS) + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ELEMENTS - 1);
   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(drain_timeout(ELEMENTS) - 1);

   seq_state_e state, state_nxt;

   logic                 s_open, beat, take, m_xfer, drain_done;
   logic [CNT_W-1:0]     rd_addr, frame_count_q;
   logic [TMR_W-1:0]     drain_tmr;
   logic                 overflow_q;

   logic                 srt_in_valid_q, srt_in_last_q;
   logic [BIT_WIDTH-1:0] srt_in_data_q;
   METADATA_TYPE         srt_in_meta_q;

   logic                 m_valid_q, m_last_q;
   logic [BIT_WIDTH-1:0] m_data_q;
   METADATA_TYPE         m_meta_q;

   assign s_open     = (state == S_LOAD) || (state == S_DISCARD);
   assign beat       = bus.s_valid && s_open;
   assign m_xfer     = m_valid_q && bus.m_ready;
   assign take       = (state == S_READ) && (!m_valid_q || bus.m_ready) && (rd_addr < frame_count_q);
   assign drain_done = bus.srt_out_last || (drain_tmr == TMO_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_CLEAR;
         S_CLEAR: state_nxt = S_LOAD;
         S_LOAD: begin
            if (beat) begin
               if (bus.s_last)                  state_nxt = S_DRAIN;
               else if (frame_count_q == LAST_IDX) state_nxt = S_DISCARD;
            end
         end
         S_DISCARD: if (beat && bus.s_last) state_nxt = S_DRAIN;
         S_DRAIN:   if (drain_done)          state_nxt = S_READ;
         S_READ:    if (m_xfer && m_last_q)  state_nxt = S_CLEAR;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         srt_in_valid_q <= 1'b0;
         srt_in_last_q  <= 1'b0;
         srt_in_data_q  <= '0;
         srt_in_meta_q  <= '0;
         overflow_q     <= 1'b0;
         frame_count_q  <= '0;
         rd_addr        <= '0;
         drain_tmr      <= '0;
         m_valid_q      <= 1'b0;
         m_last_q       <= 1'b0;
         m_data_q       <= '0;
         m_meta_q       <= '0;
      end else begin
         srt_in_valid_q <= 1'b0;
         srt_in_last_q  <= 1'b0;
         drain_tmr      <= '0;
         case (state)
            S_CLEAR: begin
               frame_count_q <= '0;
               overflow_q    <= 1'b0;
               rd_addr       <= '0;
            end
            S_LOAD: begin
               if (beat) begin
                  // A full sorter without s_last still needs a closing key, so force last.
                  srt_in_valid_q <= 1'b1;
                  srt_in_data_q  <= bus.s_data;
                  srt_in_meta_q  <= bus.s_metadata;
                  srt_in_last_q  <= bus.s_last || (frame_count_q == LAST_IDX);
                  frame_count_q  <= frame_count_q + 1'b1;
                  if (!bus.s_last && (frame_count_q == LAST_IDX)) overflow_q <= 1'b1;
               end
            end
            S_DRAIN: drain_tmr <= drain_tmr + 1'b1;
            S_READ: begin
               if (take) begin
                  m_valid_q <= 1'b1;
                  m_data_q  <= bus.srt_out_data;
                  m_meta_q  <= bus.srt_out_metadata;
                  m_last_q  <= (rd_addr == frame_count_q - 1'b1);
                  rd_addr   <= rd_addr + 1'b1;
               end else if (m_xfer) begin
                  m_valid_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state != S_IDLE);
   assign overflow    = overflow_q;
   assign frame_count = frame_count_q;

   assign bus.s_ready          = s_open;
   assign bus.m_valid          = m_valid_q;
   assign bus.m_data           = m_data_q;
   assign bus.m_metadata       = m_meta_q;
   assign bus.m_last           = m_last_q;
   // Combinational so the sorter clears in the very cycle reset is held.
   assign bus.srt_rst          = !rst_n || (state == S_CLEAR);
   assign bus.srt_in_valid     = srt_in_valid_q;
   assign bus.srt_in_data      = srt_in_data_q;
   assign bus.srt_in_metadata  = srt_in_meta_q;
   assign bus.srt_in_last      = srt_in_last_q;
   assign bus.srt_out_address  = rd_addr[ADDR_W-1:0];
endmodule

// File: tb/tb_sort_sequencer.sv
// Randomized scoreboard bench for sort_sequencer with a behavioural sorter alongside it.
module tb_sort_sequencer;
   import sort_pkg::*;

   localparam int ELEMENTS  = 8;
   localparam int BIT_WIDTH = 32;
   localparam int CNT_W     = $clog2(ELEMENTS + 1);

   typedef struct {
      logic [31:0] key;
      id_pair_s    meta;
      bit          last;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             busy, overflow;
   logic [CNT_W-1:0] frame_count;

   sort_sequencer_if #(.ELEMENTS(ELEMENTS), .BIT_WIDTH(BIT_WIDTH), .METADATA_TYPE(id_pair_s)) bus ();

   sort_sequencer #(.ELEMENTS(ELEMENTS), .BIT_WIDTH(BIT_WIDTH), .METADATA_TYPE(id_pair_s)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .busy(busy), .overflow(overflow), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   beat_t exp_q[$];
   logic [31:0] cur[$];

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   task automatic fail_timeout(input string name, input int cycles);
      chk_cnt++;
      $display("FAIL %s: no response within %0d cycles, required one", name, cycles);
   endtask

   function automatic id_pair_s meta_of(input int fid, input int idx);
      id_pair_s r;
      r.frame_id = 16'(fid);
      r.key_id   = 16'(idx);
      return r;
   endfunction

   // Behavioural sorter: stores up to ELEMENTS keys, stable insertion sort on the closing key.
   logic [31:0] srt_k [ELEMENTS];
   id_pair_s    srt_m [ELEMENTS];
   logic [31:0] sk    [ELEMENTS];
   id_pair_s    sm    [ELEMENTS];
   int          srt_cnt = 0;
   bit          srt_done = 1'b0;

   always @(posedge clk) begin : sorter_model
      logic [31:0] tk [ELEMENTS];
      id_pair_s    tm [ELEMENTS];
      logic [31:0] kv;
      id_pair_s    mv;
      int          j, n;
      if (bus.srt_rst) begin
         srt_cnt  <= 0;
         srt_done <= 1'b0;
      end else if (bus.srt_in_valid) begin
         tk = srt_k;
         tm = srt_m;
         if (srt_cnt < ELEMENTS) begin
            tk[srt_cnt] = bus.srt_in_data;
            tm[srt_cnt] = bus.srt_in_metadata;
         end
         srt_cnt <= srt_cnt + 1;
         srt_k   <= tk;
         srt_m   <= tm;
         if (bus.srt_in_last) begin
            n = (srt_cnt + 1 < ELEMENTS) ? srt_cnt + 1 : ELEMENTS;
            for (int i = 1; i < n; i++) begin
               kv = tk[i];
               mv = tm[i];
               j  = i - 1;
               while (j >= 0 && tk[j] > kv) begin
                  tk[j+1] = tk[j];
                  tm[j+1] = tm[j];
                  j--;
               end
               tk[j+1] = kv;
               tm[j+1] = mv;
            end
            sk       <= tk;
            sm       <= tm;
            srt_done <= 1'b1;
         end
      end
   end

   assign bus.srt_out_last     = srt_done;
   assign bus.srt_out_data     = sk[bus.srt_out_address];
   assign bus.srt_out_metadata = sm[bus.srt_out_address];

   // Downstream ready: 0 always ready, 1 random, 2 repeating 1,0,0,1.
   int ready_mode = 0;
   int rpat = 0;
   initial begin
      bus.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rpat++;
         case (ready_mode)
            1:       bus.m_ready = ($urandom_range(0, 3) != 0);
            2:       bus.m_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3);
            default: bus.m_ready = 1'b1;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every downstream transfer and checks stall stability.
   bit          prev_stall = 1'b0;
   logic [31:0] prev_d;
   id_pair_s    prev_m;
   logic        prev_l;
   always @(negedge clk) begin : monitor
      beat_t e;
      bit    got;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check(bus.m_valid && bus.m_data == prev_d && bus.m_metadata == prev_m && bus.m_last == prev_l,
                  "stall_hold", {31'd0, bus.m_valid, bus.m_data}, {32'd1, prev_d});
         if (bus.m_valid && bus.m_ready) begin
            got = (exp_q.size() > 0);
            if (got) e = exp_q.pop_front();
            else begin e.key = '0; e.meta = '0; e.last = 1'b0; end
            check(got && bus.m_data == e.key && bus.m_metadata == e.meta && bus.m_last == e.last, "out_beat",
                  {bus.m_metadata, bus.m_data[30:0], bus.m_last}, {e.meta, e.key[30:0], e.last});
         end
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_d     = bus.m_data;
         prev_m     = bus.m_metadata;
         prev_l     = bus.m_last;
      end
   end

   // Sends cur[] as one frame; abort_after > 0 pulses reset once that many beats have left.
   task automatic send_frame(input int fid, input int abort_after);
      int    n, m, rank, waitc;
      bit    acc;
      beat_t exp_a [ELEMENTS];
      n = cur.size();
      m = (n < ELEMENTS) ? n : ELEMENTS;
      for (int i = 0; i < m; i++) begin
         rank = 0;
         for (int j = 0; j < m; j++)
            if (cur[j] < cur[i] || (cur[j] == cur[i] && j < i)) rank++;
         exp_a[rank].key  = cur[i];
         exp_a[rank].meta = meta_of(fid, i);
         exp_a[rank].last = (rank == m - 1);
      end
      for (int i = 0; i < m; i++) exp_q.push_back(exp_a[i]);

      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
         bus.s_valid    = 1'b1;
         bus.s_data     = cur[i];
         bus.s_metadata = meta_of(fid, i);
         bus.s_last     = (i == n - 1);
         waitc = 0;
         do begin @(negedge clk); acc = bus.s_ready; waitc++; end while (!acc && waitc < 100);
         @(posedge clk); #1;
         bus.s_valid = 1'b0;
         bus.s_last  = 1'b0;
         if (!acc) begin fail_timeout("s_ready_wait", waitc); exp_q.delete(); return; end
      end

      waitc = 0;
      while (!bus.m_valid && waitc < 60) begin @(negedge clk); waitc++; end
      if (!bus.m_valid) begin fail_timeout("m_valid_wait", waitc); exp_q.delete(); return; end
      check(overflow == (n > ELEMENTS), "overflow", overflow, (n > ELEMENTS));
      check(frame_count == CNT_W'(m), "frame_count", frame_count, m);
      check(srt_cnt == m, "sorter_rx_count", srt_cnt, m);

      if (abort_after > 0) begin
         waitc = 0;
         do begin @(posedge clk); #2; waitc++; end
         while (exp_q.size() > m - abort_after && waitc < 60);
         rst_n = 1'b0;
         #1;
         check(bus.srt_rst == 1'b1, "abort_srt_rst", bus.srt_rst, 1);
         @(posedge clk); #2;
         check(bus.m_valid == 1'b0, "abort_m_valid", bus.m_valid, 0);
         check(busy == 1'b0, "abort_busy", busy, 0);
         rst_n = 1'b1;
         exp_q.delete();
         @(posedge clk); #1;
         return;
      end

      waitc = 0;
      while (exp_q.size() > 0 && waitc < 300) begin @(negedge clk); waitc++; end
      if (exp_q.size() > 0) begin fail_timeout("readout", waitc); exp_q.delete(); end
      waitc = 0;
      while (!bus.s_ready && waitc < 3) begin @(negedge clk); waitc++; end
      check(bus.s_ready == 1'b1, "back_to_load", bus.s_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   initial begin
      bus.s_valid    = 1'b0;
      bus.s_data     = '0;
      bus.s_metadata = '0;
      bus.s_last     = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check(bus.s_ready == 1'b0,      "rst_s_ready",      bus.s_ready,      0);
      check(bus.m_valid == 1'b0,      "rst_m_valid",      bus.m_valid,      0);
      check(bus.m_last == 1'b0,       "rst_m_last",       bus.m_last,       0);
      check(bus.srt_in_valid == 1'b0, "rst_srt_in_valid", bus.srt_in_valid, 0);
      check(bus.srt_in_last == 1'b0,  "rst_srt_in_last",  bus.srt_in_last,  0);
      check(overflow == 1'b0,         "rst_overflow",     overflow,         0);
      check(frame_count == '0,        "rst_frame_count",  frame_count,      0);
      check(busy == 1'b0,             "rst_busy",         busy,             0);
      check(bus.srt_rst == 1'b1,      "rst_srt_rst",      bus.srt_rst,      1);
      check(bus.srt_out_address == '0, "rst_rd_addr",     bus.srt_out_address, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check(busy == 1'b1 && bus.srt_rst == 1'b1, "clear_after_idle", {busy, bus.srt_rst}, 2'b11);

      cur = {32'd5, 32'd3, 32'd7, 32'd1};
      send_frame(1, 0);

      cur.delete();
      for (int i = 9; i >= 0; i--) cur.push_back(32'(i));
      send_frame(2, 0);

      ready_mode = 2;
      cur.delete();
      for (int i = 0; i < 4; i++) cur.push_back($urandom_range(0, 1000));
      send_frame(3, 0);
      ready_mode = 0;

      cur = {32'd42};
      send_frame(4, 0);

      cur = {32'd4, 32'd4, 32'd2};
      send_frame(5, 0);

      cur.delete();
      for (int i = 0; i < 4; i++) cur.push_back($urandom);
      send_frame(6, 2);

      cur.delete();
      for (int i = 0; i < 4; i++) cur.push_back($urandom_range(0, 50));
      send_frame(7, 0);

      ready_mode = 1;
      for (int f = 8; f < 20; f++) begin
         cur.delete();
         for (int i = 0; i < int'($urandom_range(1, 12)); i++) cur.push_back($urandom_range(0, 15));
         send_frame(f, 0);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
